// File: rtl/sipo_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sipo_rx_pkg
// Description : Shared definitions for the serial-in/parallel-out receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package sipo_rx_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit counter width for an n-bit word; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sipo_rx_mod_n_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod_n_counter
// Description : Modulo-n bit counter with clear and terminal-count flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_n_counter #(
    parameter int width = 3,
    parameter int n     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [width-1:0] count,
    output logic             terminal
);

    localparam logic [width-1:0] c_last = width'(n - 1);

    logic [width-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= (r_count == c_last) ? '0 : r_count + 1'b1;
        end
    end

    assign count    = r_count;
    assign terminal = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/sipo_rx.sv
`default_nettype none
// ============================================================================
// Module      : sipo_rx
// Description : Serial-in/parallel-out receiver, MSB first, with held output
//               word, acknowledge handshake and sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_rx
    import sipo_rx_pkg::*;
#(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         din,
    input  logic         en,
    input  logic         ack,
    output logic [n-1:0] dout,
    output logic         valid,
    output logic         busy,
    output logic         overrun
);

    localparam int c_cw = cnt_width(n);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_clr;
    logic            w_inc;
    logic            w_complete;
    logic            w_terminal;
    logic [c_cw-1:0] w_count_unused;
    logic [n-1:0]    r_sh;
    logic [n-1:0]    r_dout;
    logic            r_valid;
    logic            r_overrun;
    logic [n-1:0]    w_word;

    mod_n_counter #(
        .width (c_cw),
        .n     (n)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_clr),
        .inc      (w_inc),
        .count    (w_count_unused),
        .terminal (w_terminal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // start outranks en in both states; the arming edge never samples din.
    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_inc       = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = SHIFT;
                    w_clr       = 1'b1;
                end
            end
            SHIFT: begin
                if (start) begin
                    w_clr = 1'b1;
                end else if (en) begin
                    w_inc = 1'b1;
                    if (w_terminal) begin
                        w_complete  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_word = {r_sh[n-2:0], din};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh <= '0;
        end else if (w_clr) begin
            r_sh <= '0;
        end else if (w_inc) begin
            r_sh <= w_word;
        end
    end

    // A finished word is only dropped when the held one is still unacknowledged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_complete) begin
            if (!r_valid) begin
                r_dout  <= w_word;
                r_valid <= 1'b1;
            end else if (ack) begin
                r_dout    <= w_word;
                r_overrun <= 1'b0;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (ack) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign dout    = r_dout;
    assign valid   = r_valid;
    assign overrun = r_overrun;
    assign busy    = (r_state == SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_sipo_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_sipo_rx
// Description : Scoreboard bench for sipo_rx with a bit-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_rx;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         din;
    logic         en;
    logic         ack;
    logic [N-1:0] dout;
    logic         valid;
    logic         busy;
    logic         overrun;

    int errors = 0;
    int checks = 0;

    logic [N-1:0] sb[$];
    bit           bits[$];
    bit           m_busy;
    bit           m_valid;
    bit           m_overrun;
    logic [N-1:0] m_dout;
    bit           mon_on = 0;

    sipo_rx #(.n(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .din     (din),
        .en      (en),
        .ack     (ack),
        .dout    (dout),
        .valid   (valid),
        .busy    (busy),
        .overrun (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy    = 0;
        m_valid   = 0;
        m_overrun = 0;
        m_dout    = '0;
        bits.delete();
        sb.delete();
    endtask

    // Reference: collect bits after a start; the N-th enabled bit forms the word.
    task automatic model_step(input bit s, input bit e, input bit d, input bit a);
        logic [N-1:0] w;
        bit           done;
        w    = '0;
        done = 0;
        if (s) begin
            bits.delete();
            m_busy = 1;
        end else if (m_busy && e) begin
            bits.push_back(d);
            if (bits.size() == N) begin
                foreach (bits[i]) w = N'(w * 2 + N'(bits[i]));
                done   = 1;
                m_busy = 0;
                bits.delete();
            end
        end
        if (done) begin
            if (!m_valid) begin
                m_dout  = w;
                m_valid = 1;
                sb.push_back(w);
            end else if (a) begin
                m_dout    = w;
                m_overrun = 0;
                sb.push_back(w);
            end else begin
                m_overrun = 1;
            end
        end else if (a) begin
            m_valid   = 0;
            m_overrun = 0;
        end
    endtask

    task automatic cyc(input bit s, input bit e, input bit d, input bit a);
        start = s;
        en    = e;
        din   = d;
        ack   = a;
        @(posedge clk);
        model_step(s, e, d, a);
        #1;
    endtask

    task automatic send_word(input logic [N-1:0] w, input bit ack_last,
                             input int gap_a, input int gap_b);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < N; i++) begin
            cyc(0, 1, w[N-1-i], (i == N - 1) ? ack_last : 1'b0);
            if (i + 1 == gap_a || i + 1 == gap_b) cyc(0, 0, ~w[N-1-i], 0);
        end
    endtask

    // Monitor: every cycle against the model; each consumed word against the queue.
    always @(negedge clk) begin
        if (mon_on && !rst) begin
            check("valid", {31'd0, valid}, {31'd0, m_valid});
            check("busy", {31'd0, busy}, {31'd0, m_busy});
            check("overrun", {31'd0, overrun}, {31'd0, m_overrun});
            check("dout", 32'(dout), 32'(m_dout));
            if (ack && valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ack_word: got 0x%0h expected no held word", dout);
                end else begin
                    check("ack_word", 32'(dout), 32'(sb.pop_front()));
                end
            end
        end
    end

    initial begin
        logic [N-1:0] p;
        rst   = 1'b1;
        start = 1'b0;
        din   = 1'b0;
        en    = 1'b0;
        ack   = 1'b0;
        model_reset();
        #1;
        check("reset_dout", 32'(dout), 32'h0);
        check("reset_valid", {31'd0, valid}, 32'h0);
        check("reset_busy", {31'd0, busy}, 32'h0);
        check("reset_overrun", {31'd0, overrun}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        mon_on = 1;

        send_word(8'hA5, 0, 0, 0);
        check("basic_dout", 32'(dout), 32'hA5);
        check("basic_valid", {31'd0, valid}, 32'h1);
        check("basic_busy", {31'd0, busy}, 32'h0);
        cyc(0, 0, 0, 1);

        send_word(8'h5A, 0, 2, 5);
        check("gapped_dout", 32'(dout), 32'h5A);
        cyc(0, 0, 0, 1);

        cyc(1, 0, 0, 0);
        repeat (3) cyc(0, 1, 1, 0);
        send_word(8'h3C, 0, 0, 0);
        check("restart_dout", 32'(dout), 32'h3C);
        check("restart_valid", {31'd0, valid}, 32'h1);
        cyc(0, 0, 0, 1);

        send_word(8'h11, 0, 0, 0);
        send_word(8'h22, 0, 0, 0);
        check("ovr_dout", 32'(dout), 32'h11);
        check("ovr_valid", {31'd0, valid}, 32'h1);
        check("ovr_flag", {31'd0, overrun}, 32'h1);
        cyc(0, 0, 0, 1);
        check("ovr_ack_valid", {31'd0, valid}, 32'h0);
        check("ovr_ack_flag", {31'd0, overrun}, 32'h0);

        send_word(8'h11, 0, 0, 0);
        send_word(8'h22, 1, 0, 0);
        check("simul_dout", 32'(dout), 32'h22);
        check("simul_valid", {31'd0, valid}, 32'h1);
        check("simul_overrun", {31'd0, overrun}, 32'h0);
        cyc(0, 0, 0, 1);

        send_word(8'h77, 0, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (4) cyc(0, 1, 1, 0);
        start = 1'b0;
        en    = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_dout", 32'(dout), 32'h0);
        check("arst_valid", {31'd0, valid}, 32'h0);
        check("arst_busy", {31'd0, busy}, 32'h0);
        check("arst_overrun", {31'd0, overrun}, 32'h0);
        model_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        send_word(8'hFF, 0, 0, 0);
        check("arst_fresh_dout", 32'(dout), 32'hFF);
        cyc(0, 0, 0, 1);

        p = 8'hC3;
        cyc(1, 0, 0, 0);
        for (int i = 0; i < N; i++) begin
            cyc(0, 1, p[N-1], 0);
            p = {p[N-2:0], 1'b0};
        end
        check("loopback_dout", 32'(dout), 32'hC3);
        cyc(0, 0, 0, 1);

        for (int k = 0; k < 600; k++) begin
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0);
        end

        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
